// File: rtl/chip8_pkg.sv
// Shared Chip8 display geometry and the draw-engine FSM state encoding.
package chip8_pkg;

  localparam int FB_W    = 64;
  localparam int FB_H    = 32;
  localparam int FB_BITS = FB_W * FB_H;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    XOR   = 3'd3,
    DONE  = 3'd4
  } fbd_state_t;

endpackage

// File: rtl/chip8_sprite_row_mask.sv
// Expands one sprite byte into a 64-bit display-row mask anchored at column x0.
module chip8_sprite_row_mask #(
  parameter bit CLIP_EDGES = 1'b0
) (
  input  logic [7:0]  sprite_byte,
  input  logic [5:0]  x0,
  output logic [63:0] mask
);

  logic [6:0] col;

  // Bit 7 of the byte is the leftmost pixel; col[6] flags a column past the right edge.
  always_comb begin
    mask = '0;
    col  = '0;
    for (int k = 0; k < 8; k++) begin
      col = {1'b0, x0} + 7'(k);
      if (sprite_byte[7-k] && (!CLIP_EDGES || !col[6])) begin
        mask[col[5:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chip8_framebuffer_draw.sv
// Chip8 display owner: executes CLS and DRW Vx,Vy,N against a 64x32 framebuffer register.
module chip8_framebuffer_draw
  import chip8_pkg::*;
#(
  parameter bit CLIP_EDGES = 1'b0
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               clear_req,
  input  logic               draw_req,
  input  logic [7:0]         draw_x,
  input  logic [7:0]         draw_y,
  input  logic [3:0]         draw_n,
  input  logic [11:0]        sprite_addr,
  output logic [11:0]        mem_addr,
  output logic               mem_re,
  input  logic [7:0]         mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               collision,
  output logic [FB_BITS-1:0] framebuffer,
  output fbd_state_t         fsm_state
);

  fbd_state_t  state, next_state;
  logic [4:0]  row;
  logic [5:0]  x0;
  logic [4:0]  y0;
  logic [3:0]  n;
  logic [11:0] base;

  logic [5:0]  row_sum;
  logic [4:0]  yr;
  logic        row_skip;
  logic [63:0] row_bits;
  logic [63:0] mask;

  chip8_sprite_row_mask #(.CLIP_EDGES(CLIP_EDGES)) u_mask (
    .sprite_byte (mem_rdata),
    .x0          (x0),
    .mask        (mask)
  );

  assign row_sum  = {1'b0, y0} + {1'b0, row};
  assign yr       = row_sum[4:0];
  assign row_skip = CLIP_EDGES && row_sum[5];
  assign row_bits = framebuffer[{yr, 6'd0} +: 64];

  // Requests are single-cycle strobes sampled only in IDLE; anything arriving
  // while busy is dropped, and operands are captured on the accepting edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clear_req)                        next_state = CLEAR;
        else if (draw_req && draw_n != 4'd0)  next_state = FETCH;
        else if (draw_req)                    next_state = DONE;
      end
      CLEAR:   if (row == 5'd31) next_state = DONE;
      FETCH:   next_state = XOR;
      XOR:     next_state = (row == {1'b0, n} - 5'd1) ? DONE : FETCH;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_re    = (state == FETCH);
  assign mem_addr  = mem_re ? (base + 12'(row)) : 12'd0;
  assign fsm_state = state;

  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      x0          <= '0;
      y0          <= '0;
      n           <= '0;
      base        <= '0;
      collision   <= 1'b0;
      framebuffer <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (clear_req) begin
            row       <= '0;
            collision <= 1'b0;
          end else if (draw_req) begin
            x0        <= draw_x[5:0];
            y0        <= draw_y[4:0];
            n         <= draw_n;
            base      <= sprite_addr;
            row       <= '0;
            collision <= 1'b0;
          end
        end
        CLEAR: begin
          framebuffer[{row, 6'd0} +: 64] <= '0;
          row <= row + 5'd1;
        end
        XOR: begin
          // Clipped rows still advance the row counter so memory addressing stays aligned.
          if (!row_skip) begin
            framebuffer[{yr, 6'd0} +: 64] <= row_bits ^ mask;
            collision <= collision | (|(row_bits & mask));
          end
          row <= row + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer_draw.sv
// Directed bench: a wrapping and a clipping instance share stimulus and a sprite memory model.
module tb_chip8_framebuffer_draw;
  import chip8_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0, draw_req = 1'b0;
  logic [7:0]  draw_x = '0, draw_y = '0;
  logic [3:0]  draw_n = '0;
  logic [11:0] sprite_addr = '0;

  logic [11:0]        mem_addr_w, mem_addr_c;
  logic               mem_re_w, mem_re_c, busy_w, busy_c, done_w, done_c, coll_w, coll_c;
  logic [7:0]         rdata_w, rdata_c;
  logic [FB_BITS-1:0] fb_w, fb_c, exp_w, exp_c;
  fbd_state_t         st_w, st_c;
  logic [7:0]         mem [0:4095];

  int vectors = 0;
  int miscompares = 0;
  int cyc, cnt, guard, dones;

  always #5 clk = ~clk;

  chip8_framebuffer_draw #(.CLIP_EDGES(1'b0)) dut_w (
    .clk50(clk), .reset(reset), .clear_req(clear_req), .draw_req(draw_req),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .sprite_addr(sprite_addr),
    .mem_addr(mem_addr_w), .mem_re(mem_re_w), .mem_rdata(rdata_w), .busy(busy_w),
    .done(done_w), .collision(coll_w), .framebuffer(fb_w), .fsm_state(st_w));

  chip8_framebuffer_draw #(.CLIP_EDGES(1'b1)) dut_c (
    .clk50(clk), .reset(reset), .clear_req(clear_req), .draw_req(draw_req),
    .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .sprite_addr(sprite_addr),
    .mem_addr(mem_addr_c), .mem_re(mem_re_c), .mem_rdata(rdata_c), .busy(busy_c),
    .done(done_c), .collision(coll_c), .framebuffer(fb_c), .fsm_state(st_c));

  // Synchronous-read memory: data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re_w) rdata_w <= mem[mem_addr_w];
    if (mem_re_c) rdata_c <= mem[mem_addr_c];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request into the accepting edge, then scrambles the operands.
  task automatic start_op(input bit clr, input bit drw, input logic [7:0] x,
                          input logic [7:0] y, input logic [3:0] n, input logic [11:0] a);
    @(negedge clk);
    clear_req = clr; draw_req = drw; draw_x = x; draw_y = y; draw_n = n; sprite_addr = a;
    @(posedge clk);
    #1;
    clear_req = 1'b0; draw_req = 1'b0;
    draw_x = ~x; draw_y = y + 8'd3; draw_n = 4'hF; sprite_addr = a + 12'h123;
  endtask

  // Returns the cycle index (after the accepting edge) at which done is seen.
  task automatic wait_done(input int start, output int c);
    c = start;
    do begin
      @(negedge clk);
      c++;
    end while (!done_w && c < 100);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h201] = 8'h0F;
    mem[12'h210] = 8'hFF;
    mem[12'h211] = 8'h81;
    mem[12'h220] = 8'hC0;
    mem[12'hFFF] = 8'h80;
    mem[12'h000] = 8'h80;
    for (int i = 0; i < 15; i++) mem[12'h300 + 12'(i)] = 8'hFF;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t1 fb ones", 64'($countones(fb_w)), 64'd0);
    check("t1 busy", 64'(busy_w), 64'd0);
    check("t1 done", 64'(done_w), 64'd0);
    check("t1 mem_re", 64'(mem_re_w), 64'd0);
    check("t1 collision", 64'(coll_w), 64'd0);
    check("t1 state", 64'(st_w), 64'(IDLE));

    // 2: single-row draw at origin
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200);
    @(negedge clk);
    check("t2 mem_re c1", 64'(mem_re_w), 64'd1);
    check("t2 mem_addr c1", 64'(mem_addr_w), 64'h200);
    wait_done(1, cyc);
    check("t2 done cycle", 64'(cyc), 64'd3);
    exp_w = '0;
    exp_w[3:0] = 4'hF;
    check("t2 fb diff", 64'($countones(fb_w ^ exp_w)), 64'd0);
    check("t2 collision", 64'(coll_w), 64'd0);
    @(negedge clk);
    check("t2 done width", 64'(done_w), 64'd0);
    check("t2 busy after", 64'(busy_w), 64'd0);

    // 3: redraw erases and collides; disjoint sprite clears collision
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200);
    wait_done(0, cyc);
    check("t3 fb ones", 64'($countones(fb_w)), 64'd0);
    check("t3 collision", 64'(coll_w), 64'd1);
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h201);
    wait_done(0, cyc);
    check("t3b collision", 64'(coll_w), 64'd0);
    exp_w = '0;
    exp_w[7:4] = 4'hF;
    check("t3b fb diff", 64'($countones(fb_w ^ exp_w)), 64'd0);

    // 4: edge wrap vs clip
    start_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000);
    wait_done(0, cyc);
    start_op(1'b0, 1'b1, 8'd62, 8'd31, 4'd2, 12'h210);
    wait_done(0, cyc);
    check("t4 done cycle", 64'(cyc), 64'd5);
    exp_w = '0;
    exp_w[31*64+62] = 1'b1;
    exp_w[31*64+63] = 1'b1;
    for (int i = 0; i < 6; i++) exp_w[31*64+i] = 1'b1;
    exp_w[62] = 1'b1;
    exp_w[5]  = 1'b1;
    exp_c = '0;
    exp_c[31*64+62] = 1'b1;
    exp_c[31*64+63] = 1'b1;
    check("t4 wrap fb diff", 64'($countones(fb_w ^ exp_w)), 64'd0);
    check("t4 clip fb diff", 64'($countones(fb_c ^ exp_c)), 64'd0);
    check("t4 clip collision", 64'(coll_c), 64'd0);

    // 5: operand wrap, address wrap, zero-height draw
    start_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000);
    wait_done(0, cyc);
    start_op(1'b0, 1'b1, 8'd70, 8'd40, 4'd1, 12'h220);
    wait_done(0, cyc);
    exp_w = '0;
    exp_w[8*64+6] = 1'b1;
    exp_w[8*64+7] = 1'b1;
    check("t5 operand wrap fb", 64'($countones(fb_w ^ exp_w)), 64'd0);
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd2, 12'hFFF);
    @(negedge clk);
    check("t5 addr c1", 64'(mem_addr_w), 64'hFFF);
    @(negedge clk);
    @(negedge clk);
    check("t5 mem_re c3", 64'(mem_re_w), 64'd1);
    check("t5 addr c3", 64'(mem_addr_w), 64'h000);
    wait_done(3, cyc);
    check("t5 done cycle", 64'(cyc), 64'd5);
    exp_w[0]  = 1'b1;
    exp_w[64] = 1'b1;
    check("t5 addr wrap fb", 64'($countones(fb_w ^ exp_w)), 64'd0);
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd2, 12'hFFF);
    wait_done(0, cyc);
    check("t5 recollide", 64'(coll_w), 64'd1);
    exp_w[0]  = 1'b0;
    exp_w[64] = 1'b0;
    start_op(1'b0, 1'b1, 8'd9, 8'd9, 4'd0, 12'h200);
    @(negedge clk);
    check("t5 n0 done c1", 64'(done_w), 64'd1);
    check("t5 n0 mem_re", 64'(mem_re_w), 64'd0);
    check("t5 n0 collision", 64'(coll_w), 64'd0);
    check("t5 n0 fb diff", 64'($countones(fb_w ^ exp_w)), 64'd0);

    // 6: fill the screen, then CLS with an ignored mid-clear draw
    start_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000);
    wait_done(0, cyc);
    for (int x = 0; x < 64; x += 8) begin
      start_op(1'b0, 1'b1, 8'(x), 8'd0, 4'd15, 12'h300);
      wait_done(0, cyc);
      start_op(1'b0, 1'b1, 8'(x), 8'd15, 4'd15, 12'h300);
      wait_done(0, cyc);
      start_op(1'b0, 1'b1, 8'(x), 8'd30, 4'd2, 12'h300);
      wait_done(0, cyc);
    end
    check("t6 full screen", 64'($countones(fb_w)), 64'd2048);
    start_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000);
    cnt = 0;
    guard = 0;
    do begin
      @(negedge clk);
      if (busy_w) cnt++;
      draw_req = (cnt == 10);
      draw_n = 4'd1;
      sprite_addr = 12'h300;
      guard++;
    end while (busy_w && guard < 100);
    draw_req = 1'b0;
    check("t6 cls busy cycles", 64'(cnt), 64'd33);
    check("t6 cls fb ones", 64'($countones(fb_w)), 64'd0);
    @(negedge clk);
    check("t6 ignored draw", 64'(busy_w), 64'd0);

    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200);
    wait_done(0, cyc);
    start_op(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200);
    wait_done(0, cyc);
    check("t6 clear wins cycle", 64'(cyc), 64'd33);
    check("t6 clear wins fb", 64'($countones(fb_w)), 64'd0);

    // reset in the middle of a draw
    start_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd15, 12'h300);
    repeat (3) @(negedge clk);
    check("t6 pre-reset fb", 64'($countones(fb_w)), 64'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6 reset busy", 64'(busy_w), 64'd0);
    check("t6 reset fb", 64'($countones(fb_w)), 64'd0);
    check("t6 reset clip fb", 64'($countones(fb_c)), 64'd0);
    check("t6 reset state", 64'(st_w), 64'(IDLE));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_w) dones++;
    end
    check("t6 no done after reset", 64'(dones), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
